// File: rtl/spi_pkg.sv
// Shared types for the SPI minion endpoint.
package spi_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, FRAME_END} state_t;
endpackage

// File: rtl/spi_minion_sync.sv
// Two-flop synchronizer with a trailing flop for edge detection on the synced value.
module spi_minion_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;
endmodule

// File: rtl/spi_minion.sv
// SPI mode-0 minion: deframes mosi words onto send, shifts a preloaded recv word out on miso.
module spi_minion
  import spi_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             overflow
);
  localparam int CW = $clog2(nbits + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(nbits);
  localparam logic [CW-1:0] CNT_SAT  = CW'(nbits + 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_minion_sync #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(cs), .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));
  spi_minion_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d(sclk), .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall));
  spi_minion_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d(mosi), .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_sync = ^{sclk_sync, mosi_rise, mosi_fall};

  state_t           state, state_nx;
  logic [nbits-1:0] tx_sr, rx_sr, tx_buf;
  logic             tx_valid;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_IDLE: if (cs_sync) state_nx = IDLE;
      IDLE:      if (cs_fall) state_nx = ACTIVE;
      ACTIVE:    if (cs_rise) state_nx = FRAME_END;
      FRAME_END: state_nx = IDLE;
      default:   state_nx = WAIT_IDLE;
    endcase
  end

  assign recv_rdy = ~tx_valid;
  assign miso     = (state == ACTIVE) & tx_sr[nbits-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      tx_buf   <= '0;
      tx_valid <= 1'b0;
      cnt      <= '0;
      send_val <= 1'b0;
      send_msg <= '0;
      overflow <= 1'b0;
    end else begin
      if (send_val && send_rdy) send_val <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          tx_sr    <= tx_valid ? tx_buf : '0;
          tx_valid <= 1'b0;
          cnt      <= '0;
        end
        ACTIVE: begin
          if (sclk_rise) begin
            rx_sr <= {rx_sr[nbits-2:0], mosi_sync};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
          if (sclk_fall) tx_sr <= {tx_sr[nbits-2:0], 1'b0};
        end
        FRAME_END: if (cnt == CNT_FULL) begin
          // A word still held (even one being handshaken now) means this one is lost.
          if (!send_val) begin
            send_msg <= rx_sr;
            send_val <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
      // After the frame-start clear so a coincident load survives for the next frame.
      if (recv_val && recv_rdy) begin
        tx_buf   <= recv_msg;
        tx_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_minion.sv
// Randomized scoreboard bench for spi_minion with a frame-level reference model.
module tb_spi_minion;
  localparam int NB = 8;
  localparam int HP = 6;

  logic clk = 1'b0;
  logic reset, cs, sclk, mosi, miso;
  logic recv_val, recv_rdy, send_val, send_rdy, overflow;
  logic [NB-1:0] recv_msg, send_msg;

  int errors = 0;
  int checks = 0;

  // Reference model: one-entry tx buffer, queue of delivered-but-unconsumed words, sticky overflow.
  logic [NB-1:0] exp_q[$];
  logic          m_tx_valid = 1'b0;
  logic [NB-1:0] m_tx_buf = '0;
  logic          m_ovf = 1'b0;

  always #5 clk = ~clk;

  spi_minion #(.nbits(NB)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .overflow(overflow));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every send handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && send_val && send_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL send_unexpected: got %0h expected none", send_msg);
      end else begin
        if (send_msg !== exp_q[0]) begin
          errors++;
          $display("FAIL send_msg: got %0h expected %0h", send_msg, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic load_recv(input logic [NB-1:0] w);
    int n = 0;
    while (!recv_rdy && n < 10) begin
      tick();
      n++;
    end
    if (!recv_rdy) begin
      checks++;
      errors++;
      $display("FAIL recv_rdy_timeout: got 0 expected 1");
    end
    recv_val = 1'b1;
    recv_msg = w;
    tick();
    recv_val = 1'b0;
    m_tx_valid = 1'b1;
    m_tx_buf = w;
    chk("recv_rdy_after_load", recv_rdy, 0);
  endtask

  // One master frame of nb bits; optionally pulse recv exactly on the cs-fall load cycle.
  task automatic frame(input int nb, input logic [15:0] word, input bit coinc,
                       input logic [NB-1:0] cword, input string tag);
    logic [NB-1:0] txw;
    logic [15:0]   got, expb;
    txw = m_tx_valid ? m_tx_buf : '0;
    m_tx_valid = 1'b0;
    got = '0;
    expb = '0;
    cs = 1'b0;
    mosi = word[nb-1];
    if (coinc) begin
      tick(2);
      recv_val = 1'b1;
      recv_msg = cword;
      tick(1);
      recv_val = 1'b0;
      m_tx_valid = 1'b1;
      m_tx_buf = cword;
      tick(HP - 3);
    end else begin
      tick(HP);
    end
    for (int i = 0; i < nb; i++) begin
      got = {got[14:0], miso};
      sclk = 1'b1;
      tick(HP);
      sclk = 1'b0;
      if (i < nb - 1) mosi = word[nb-2-i];
      tick(HP);
    end
    for (int i = 0; i < nb; i++)
      expb = {expb[14:0], (i < NB) ? txw[NB-1-i] : 1'b0};
    chk({tag, "_miso"}, got, expb);
    cs = 1'b1;
    if (nb == NB) begin
      if (exp_q.size() != 0) m_ovf = 1'b1;
      else exp_q.push_back(word[NB-1:0]);
    end
    tick(8);
    chk({tag, "_overflow"}, overflow, m_ovf);
    chk({tag, "_recv_rdy"}, recv_rdy, !m_tx_valid);
    chk({tag, "_send_val"}, send_val, exp_q.size() != 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_recv_rdy"}, recv_rdy, 1);
    chk({tag, "_send_val"}, send_val, 0);
    chk({tag, "_send_msg"}, send_msg, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b1;
    tick(3);
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick(5);

    load_recv(8'hA5);
    frame(NB, 16'h3C, 0, 0, "a5_3c");
    frame(NB, 16'hFF, 0, 0, "empty_ff");
    frame(5, 16'h15, 0, 0, "short5");
    frame(9, 16'h1AB, 0, 0, "long9");

    send_rdy = 1'b0;
    frame(NB, 16'h11, 0, 0, "hold_11");
    frame(NB, 16'h22, 0, 0, "ovf_22");
    chk("ovf_held_msg", send_msg, 8'h11);
    send_rdy = 1'b1;
    tick(3);
    chk("ovf_drained", send_val, 0);

    frame(NB, 16'h33, 1, 8'h5A, "coinc_load");
    frame(NB, 16'h44, 0, 0, "coinc_next");

    // Reset mid-frame with cs held low: the remaining bits must not produce a word.
    cs = 1'b0;
    mosi = 1'b1;
    tick(HP);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; tick(HP); sclk = 1'b0; tick(HP);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_tx_valid = 1'b0;
    m_ovf = 1'b0;
    exp_q.delete();
    chk_reset_outputs("midreset");
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1; tick(HP); sclk = 1'b0; tick(HP);
    end
    cs = 1'b1;
    tick(8);
    chk("midreset_no_send", send_val, 0);
    chk("midreset_no_ovf", overflow, 0);
    frame(NB, 16'h81, 0, 0, "after_reset");

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(1) == 1 && !m_tx_valid) load_recv(NB'($urandom));
      frame(NB, 16'($urandom_range(255)), 0, 0, "rand");
    end

    tick(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
